// File: rtl/sad_pkg.sv
// Shared types and constants for the SAD window address generator.
package sad_pkg;

    localparam int unsigned WORD_BYTES = 4;
    localparam int unsigned ADDR_W     = 32;
    localparam int unsigned WORD_SHIFT = $clog2(WORD_BYTES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/sad_dim_counter.sv
// Loadable up-counter with a terminal flag; used for the column and row of the sweep.
module sad_dim_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         inc,
    input  logic [W-1:0] last_val,
    output logic         term
);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (inc)
            count <= count + 1'b1;
    end

    assign term = (count == last_val);

endmodule

// File: rtl/sad_window_agu.sv
// Address generator sweeping a MemWidth x MemHeight word window inside a frame.
// Optional SAD_AGU_ERRCHK_EN rejects empty windows and windows wider than the frame.
module sad_window_agu
    import sad_pkg::*;
(
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Start,
    input  logic [ADDR_W-1:0] BaseAddr,
    input  logic [ADDR_W-1:0] MemWidth,
    input  logic [ADDR_W-1:0] MemHeight,
    input  logic [ADDR_W-1:0] FrameWidth,
    input  logic              AddrReady,
    output logic              AddrValid,
    output logic [ADDR_W-1:0] Addr,
    output logic              RowLast,
    output logic              WinLast,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q, row_base_q, pitch_q;
    logic [ADDR_W-1:0] w_last_q, h_last_q;
    logic              col_term, row_term;
    logic              dims_zero, start_ok, start_fire, hs, row_wrap;

    assign dims_zero = (MemWidth == '0) || (MemHeight == '0);
`ifdef SAD_AGU_ERRCHK_EN
    assign start_ok  = !dims_zero && (MemWidth <= FrameWidth);
`else
    assign start_ok  = !dims_zero;
`endif

    assign start_fire = (state_q == IDLE) && Start && start_ok;
    assign hs         = (state_q == RUN) && AddrReady;
    assign row_wrap   = hs && col_term;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (start_ok)
                        state_d = RUN;
`ifndef SAD_AGU_ERRCHK_EN
                    else
                        state_d = DONE;
`endif
                end
            end
            RUN:     if (row_wrap && row_term) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Row starts are accumulated by the byte pitch, so no row*FrameWidth product exists.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            addr_q     <= '0;
            row_base_q <= '0;
            pitch_q    <= '0;
            w_last_q   <= '0;
            h_last_q   <= '0;
        end else if (start_fire) begin
            addr_q     <= BaseAddr;
            row_base_q <= BaseAddr;
            pitch_q    <= FrameWidth << WORD_SHIFT;
            w_last_q   <= MemWidth - 1'b1;
            h_last_q   <= MemHeight - 1'b1;
        end else if (hs) begin
            if (col_term) begin
                row_base_q <= row_base_q + pitch_q;
                addr_q     <= row_base_q + pitch_q;
            end else begin
                addr_q     <= addr_q + ADDR_W'(WORD_BYTES);
            end
        end
    end

    sad_dim_counter #(.W(ADDR_W)) u_col (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .load     (start_fire || row_wrap),
        .load_val ('0),
        .inc      (hs),
        .last_val (w_last_q),
        .term     (col_term)
    );

    sad_dim_counter #(.W(ADDR_W)) u_row (
        .clk      (Clk),
        .rst_n    (Rst_n),
        .load     (start_fire),
        .load_val ('0),
        .inc      (row_wrap),
        .last_val (h_last_q),
        .term     (row_term)
    );

`ifdef SAD_AGU_ERRCHK_EN
    logic err_q;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            err_q <= 1'b0;
        else
            err_q <= (state_q == IDLE) && Start && !start_ok;
    end

    assign Err = err_q;
`else
    assign Err = 1'b0;
`endif

    assign AddrValid = (state_q == RUN);
    assign Addr      = addr_q;
    assign RowLast   = AddrValid && col_term;
    assign WinLast   = RowLast && row_term;
    assign Busy      = (state_q != IDLE);
    assign Done      = (state_q == DONE);

endmodule

// File: tb/tb_sad_window_agu.sv
// Self-checking bench for sad_window_agu: directed and randomized sweeps vs. a formula model.
module tb_sad_window_agu;

`ifdef SAD_AGU_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Rst_n;
    logic        Start;
    logic [31:0] BaseAddr, MemWidth, MemHeight, FrameWidth;
    logic        AddrReady;
    logic        AddrValid;
    logic [31:0] Addr;
    logic        RowLast, WinLast, Busy, Done, Err;

    int n_vec = 0;
    int n_err = 0;

    sad_window_agu dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .Start      (Start),
        .BaseAddr   (BaseAddr),
        .MemWidth   (MemWidth),
        .MemHeight  (MemHeight),
        .FrameWidth (FrameWidth),
        .AddrReady  (AddrReady),
        .AddrValid  (AddrValid),
        .Addr       (Addr),
        .RowLast    (RowLast),
        .WinLast    (WinLast),
        .Busy       (Busy),
        .Done       (Done),
        .Err        (Err)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // mode: 0 = ready always, 1 = ready on alternate cycles, 2 = random ready
    task automatic sweep(input logic [31:0] b, input logic [31:0] w, input logic [31:0] h,
                         input logic [31:0] fw, input int mode, input bit mid_start);
        int          n, idx, cyc;
        logic [31:0] r, c, ea;
        bit          rdy;
        @(negedge Clk);
        BaseAddr = b; MemWidth = w; MemHeight = h; FrameWidth = fw;
        Start = 1'b1; AddrReady = 1'b1;
        @(negedge Clk);
        // scramble inputs so a sweep that re-reads them would be caught
        Start = 1'b0;
        BaseAddr = $urandom; MemWidth = $urandom_range(0, 9);
        MemHeight = $urandom_range(0, 9); FrameWidth = $urandom;
        if (ERRCHK && (w == 0 || h == 0 || w > fw)) begin
            chk("err_pulse", Err, 1); chk("err_done", Done, 0);
            chk("err_valid", AddrValid, 0); chk("err_busy", Busy, 0);
            @(negedge Clk);
            chk("err_clear", Err, 0); chk("err_done2", Done, 0);
        end else if (w == 0 || h == 0) begin
            chk("zero_done", Done, 1); chk("zero_valid", AddrValid, 0); chk("zero_err", Err, 0);
            @(negedge Clk);
            chk("zero_done2", Done, 0); chk("zero_busy", Busy, 0);
        end else begin
            n = int'(w * h); idx = 0; cyc = 0;
            while (idx < n && cyc < 4 * n + 20) begin
                r  = 32'(idx) / w;
                c  = 32'(idx) % w;
                ea = b + 32'd4 * (r * fw + c);
                chk("valid", AddrValid, 1);
                chk("addr", Addr, ea);
                chk("rowlast", RowLast, 32'(c == w - 1));
                chk("winlast", WinLast, 32'((c == w - 1) && (r == h - 1)));
                chk("done_early", Done, 0);
                chk("err_run", Err, 0);
                chk("busy_run", Busy, 1);
                Start = (mid_start && idx == 1);
                if (mode == 0)      rdy = 1'b1;
                else if (mode == 1) rdy = (cyc % 2 == 1);
                else                rdy = 1'($urandom_range(0, 1));
                AddrReady = rdy;
                if (rdy) idx++;
                cyc++;
                @(negedge Clk);
            end
            Start = 1'b0;
            chk("timeout", 32'(idx), 32'(n));
            chk("done_pulse", Done, 1); chk("valid_off", AddrValid, 0); chk("busy_done", Busy, 1);
            @(negedge Clk);
            chk("done_clear", Done, 0); chk("busy_idle", Busy, 0);
        end
    endtask

    initial begin
        logic [31:0] w, h, fw;
        Rst_n = 1'b0; Start = 1'b0; AddrReady = 1'b0;
        BaseAddr = '0; MemWidth = '0; MemHeight = '0; FrameWidth = '0;
        @(negedge Clk);
        chk("rst_valid", AddrValid, 0); chk("rst_addr", Addr, 0); chk("rst_rowlast", RowLast, 0);
        chk("rst_winlast", WinLast, 0); chk("rst_busy", Busy, 0); chk("rst_done", Done, 0);
        chk("rst_err", Err, 0);
        @(posedge Clk);
        #2 Rst_n = 1'b1;

        sweep(32'h1000, 3, 2, 8, 0, 1'b0);
        sweep(32'h1000, 3, 2, 8, 1, 1'b0);
        sweep(32'h1000, 0, 2, 8, 0, 1'b0);
        sweep(32'h1000, 3, 0, 8, 0, 1'b0);
        sweep(32'hFFFF_FFF8, 4, 1, 8, 0, 1'b1);
        sweep(32'h0000_0040, 1, 3, 2, 2, 1'b0);
        sweep(32'h0000_0100, 5, 2, 3, 0, 1'b0);

        // async reset in the middle of a sweep, then restart from the base
        @(negedge Clk);
        BaseAddr = 32'h2000; MemWidth = 3; MemHeight = 2; FrameWidth = 8;
        Start = 1'b1; AddrReady = 1'b1;
        @(negedge Clk); Start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        chk("pre_rst_addr", Addr, 32'h2008);
        Rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", AddrValid, 0); chk("mid_rst_busy", Busy, 0);
        chk("mid_rst_addr", Addr, 0); chk("mid_rst_rowlast", RowLast, 0);
        #1 Rst_n = 1'b1;
        sweep(32'h2000, 3, 2, 8, 0, 1'b0);

        for (int k = 0; k < 24; k++) begin
            w  = $urandom_range(1, 6);
            h  = $urandom_range(1, 4);
            fw = (k % 4 == 3) ? 32'($urandom_range(0, 10)) : w + $urandom_range(0, 5);
            sweep($urandom, w, h, fw, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sad_window_agu.md
SAD_WINDOW_AGU -- requirements
Module: sad_window_agu

Interface
REQ-001 The block SHALL expose Clk, input, 1, the single rising-edge clock for all state.
REQ-002 The block SHALL expose Rst_n, input, 1, an asynchronous active-low reset.
REQ-003 The block SHALL expose Start, input, 1, a request to begin one window sweep.
REQ-004 The block SHALL expose BaseAddr, input, 32, the byte address of window pixel (0,0).
REQ-005 The block SHALL expose MemWidth, input, 32, the window width in words, supplied by the SAD window register.
REQ-006 The block SHALL expose MemHeight, input, 32, the window height in rows, supplied by the SAD window register.
REQ-007 The block SHALL expose FrameWidth, input, 32, the frame row pitch in words, supplied by the SAD window register.
REQ-008 The block SHALL expose AddrReady, input, 1, the consumer's acceptance of Addr.
REQ-009 The block SHALL expose AddrValid, output, 1, which is high when Addr is valid.
REQ-010 The block SHALL expose Addr, output, 32, the current byte address.
REQ-011 The block SHALL expose RowLast, output, 1, which is high with the last address of each row.
REQ-012 The block SHALL expose WinLast, output, 1, which is high with the final address of the window.
REQ-013 The block SHALL expose Busy, output, 1, which is high in any state other than IDLE.
REQ-014 The block SHALL expose Done, output, 1, a one-cycle pulse at sweep end.
REQ-015 The block SHALL expose Err, output, 1, a one-cycle pulse on rejected configuration.

Function
REQ-016 The block SHALL have three states: IDLE, RUN and DONE.
REQ-017 In IDLE with Start=1, the block SHALL latch BaseAddr, MemWidth, MemHeight and FrameWidth, then enter RUN; AddrValid SHALL rise on the next cycle with Addr=BaseAddr.
REQ-018 Addresses SHALL follow Addr = BaseAddr + 4*(row*FrameWidth + col), with col running 0..MemWidth-1 innermost and row running 0..MemHeight-1, computed by accumulators without multipliers and wrapping modulo 2^32.
REQ-019 An address SHALL advance only on a cycle where AddrValid=1 and AddrReady=1; while AddrReady=0, Addr, RowLast and WinLast SHALL hold stable.
REQ-020 The sweep SHALL issue one address per cycle when AddrReady stays high, for MemWidth*MemHeight transfers in total.
REQ-021 The handshake of the last address SHALL move the block to DONE; DONE SHALL assert Done for one cycle and then return to IDLE, with AddrValid=0.
REQ-022 Start SHALL be ignored while Busy=1, and later changes to the input dimensions SHALL NOT affect a sweep in progress.
REQ-023 If MemWidth=0 or MemHeight=0 at Start, the block SHALL issue no addresses and SHALL go directly to DONE.
REQ-024 When MemWidth=1, RowLast SHALL be asserted on every address.

Reset
REQ-025 Rst_n=0 SHALL immediately force IDLE and set all outputs and latched registers to 0, including during an active sweep.
REQ-026 After reset releases, the block SHALL accept a new Start on the first clock edge.

Configuration
REQ-027 When SAD_AGU_ERRCHK_EN is defined, a Start with MemWidth>FrameWidth or MemHeight=0 or MemWidth=0 SHALL pulse Err for one cycle, issue no addresses, assert no Done, and remain in IDLE.
REQ-028 When SAD_AGU_ERRCHK_EN is undefined, Err SHALL be tied to 0, REQ-023 SHALL apply, and MemWidth>FrameWidth SHALL be swept unchecked.

Structure
REQ-029 The shared package sad_pkg SHALL hold the state enum (IDLE/RUN/DONE) and the constant WORD_BYTES=4.
REQ-030 A single sub-module, sad_dim_counter, SHALL be used: a 32-bit loadable up-counter with a terminal flag, instantiated once for the column and once for the row.

Verification
REQ-031 Base=0x1000, W=3, H=2, FW=8, with Ready held at 1, SHALL produce 0x1000, 0x1004, 0x1008 (RowLast), 0x1020, 0x1024, 0x1028 (RowLast, WinLast), followed by Done one cycle later.
REQ-032 The same configuration with Ready low on alternate cycles SHALL produce an identical address sequence, with Addr held stable on each stall.
REQ-033 W=0 without the macro SHALL produce Done on the cycle after Start, with no AddrValid; with the macro, Err SHALL pulse and Done SHALL stay 0.
REQ-034 Rst_n pulsed low after the 2nd address SHALL immediately clear AddrValid and Busy, and a subsequent Start SHALL restart the sweep from BaseAddr.
REQ-035 Base=0xFFFFFFF8, W=4, H=1 SHALL produce 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000, 0x00000004, and a Start issued mid-sweep SHALL be ignored.
